// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Two-port round-robin arbiter and access sequencer for the 4 KB word-addressed
// data memory. Port 0 is the CPU load/store path, port 1 a DMA/debug master.
// Both ports are serialised onto the memory's single addr/din/DMWr/dout
// interface using a req/ack handshake. A per-access lock lets one master keep
// the memory for multi-word sequences.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   mN_req_i / mN_we_i        request (held until ack) / write-not-read
//   mN_lock_i                 keep priority after this access
//   mN_addr_i / mN_wdata_i    word address / write data (stable while req)
//   mN_rdata_o / mN_ack_o     read data (held) / one-cycle completion pulse
//   dm_addr_o, dm_din_o       memory address / write data
//   dm_dmwr_o                 memory write enable (memory writes on negedge)
//   dm_dout_i                 memory combinational read data
//   busy_o                    high during the single ACCESS cycle
//   gnt_id_o                  port owning the current/last access
// -----------------------------------------------------------------------------
module dm_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic          m0_lock_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic [DW-1:0] m0_rdata_o,
    output logic          m0_ack_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic          m1_lock_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic [DW-1:0] m1_rdata_o,
    output logic          m1_ack_o,
    output logic [AW-1:0] dm_addr_o,
    output logic [DW-1:0] dm_din_o,
    output logic          dm_dmwr_o,
    input  logic [DW-1:0] dm_dout_i,
    output logic          busy_o,
    output logic          gnt_id_o
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          locked_q, locked_d;
    logic          gnt_id_q, gnt_id_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] dm_addr_q, dm_addr_d;
    logic [DW-1:0] dm_din_q, dm_din_d;
    logic          dm_dmwr_q, dm_dmwr_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;

    logic          elig0_s, elig1_s;
    logic          owner_elig_s, other_elig_s, owner_ack_s;
    logic          grant_s, winner_s;

    // A request presented in its own ack cycle is stale and must be ignored.
    assign elig0_s = m0_req_i & ~m0_ack_q;
    assign elig1_s = m1_req_i & ~m1_ack_q;

    // The lock owner is always the most recent winner.
    assign owner_elig_s = last_q ? elig1_s : elig0_s;
    assign other_elig_s = last_q ? elig0_s : elig1_s;
    assign owner_ack_s  = last_q ? m1_ack_q : m0_ack_q;

    // Grant selection: lock owner first, otherwise round-robin against last.
    always_comb begin
        grant_s  = 1'b0;
        winner_s = 1'b0;
        if (locked_q) begin
            // The owner cannot re-request during its own ack cycle, so hold
            // off for that one cycle instead of handing the memory away.
            if (owner_ack_s) begin
                grant_s  = 1'b0;
                winner_s = 1'b0;
            end else if (owner_elig_s) begin
                grant_s  = 1'b1;
                winner_s = last_q;
            end else if (other_elig_s) begin
                // Abandoned lock: the other port takes over and its own lock
                // input decides the new locked state at completion.
                grant_s  = 1'b1;
                winner_s = ~last_q;
            end else begin
                grant_s  = 1'b0;
                winner_s = 1'b0;
            end
        end else if (elig0_s && elig1_s) begin
            grant_s  = 1'b1;
            winner_s = ~last_q;
        end else if (elig0_s) begin
            grant_s  = 1'b1;
            winner_s = 1'b0;
        end else if (elig1_s) begin
            grant_s  = 1'b1;
            winner_s = 1'b1;
        end else begin
            grant_s  = 1'b0;
            winner_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ACCESS always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output next-values: latch the winner in IDLE, complete it in ACCESS.
    always_comb begin
        last_d     = last_q;
        locked_d   = locked_q;
        gnt_id_d   = gnt_id_q;
        busy_d     = 1'b0;
        dm_addr_d  = dm_addr_q;
        dm_din_d   = dm_din_q;
        dm_dmwr_d  = 1'b0;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    dm_addr_d = winner_s ? m1_addr_i  : m0_addr_i;
                    dm_din_d  = winner_s ? m1_wdata_i : m0_wdata_i;
                    dm_dmwr_d = winner_s ? m1_we_i    : m0_we_i;
                    gnt_id_d  = winner_s;
                    busy_d    = 1'b1;
                end else begin
                    dm_dmwr_d = 1'b0;
                    busy_d    = 1'b0;
                end
            end
            ST_ACCESS: begin
                last_d   = gnt_id_q;
                locked_d = gnt_id_q ? m1_lock_i : m0_lock_i;
                if (gnt_id_q) begin
                    m1_ack_d = 1'b1;
                    if (!dm_dmwr_q) begin
                        m1_rdata_d = dm_dout_i;
                    end else begin
                        m1_rdata_d = m1_rdata_q;
                    end
                end else begin
                    m0_ack_d = 1'b1;
                    if (!dm_dmwr_q) begin
                        m0_rdata_d = dm_dout_i;
                    end else begin
                        m0_rdata_d = m0_rdata_q;
                    end
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Output and arbitration-history registers; last resets to 1 so port 0
    // wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= 1'b1;
            locked_q   <= 1'b0;
            gnt_id_q   <= 1'b0;
            busy_q     <= 1'b0;
            dm_addr_q  <= {AW{1'b0}};
            dm_din_q   <= {DW{1'b0}};
            dm_dmwr_q  <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= {DW{1'b0}};
            m1_rdata_q <= {DW{1'b0}};
        end else begin
            last_q     <= last_d;
            locked_q   <= locked_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            dm_addr_q  <= dm_addr_d;
            dm_din_q   <= dm_din_d;
            dm_dmwr_q  <= dm_dmwr_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign m0_rdata_o = m0_rdata_q;
    assign m0_ack_o   = m0_ack_q;
    assign m1_rdata_o = m1_rdata_q;
    assign m1_ack_o   = m1_ack_q;
    assign dm_addr_o  = dm_addr_q;
    assign dm_din_o   = dm_din_q;
    assign dm_dmwr_o  = dm_dmwr_q;
    assign busy_o     = busy_q;
    assign gnt_id_o   = gnt_id_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Directed bench for dm_arbiter with a 1024-word memory model that writes on
// the falling clock edge and reads combinationally.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_lock, m0_ack;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_lock, m1_ack;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_din, dm_dout;
    logic          dm_dmwr, busy, gnt_id;

    logic [DW-1:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory model: write on negedge, combinational read.
    always @(negedge clk) begin
        if (dm_dmwr) mem[dm_addr] <= dm_din;
    end
    assign dm_dout = mem[dm_addr];

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_rdata_o(m0_rdata), .m0_ack_o(m0_ack),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_rdata_o(m1_rdata), .m1_ack_o(m1_ack),
        .dm_addr_o(dm_addr), .dm_din_o(dm_din), .dm_dmwr_o(dm_dmwr),
        .dm_dout_i(dm_dout), .busy_o(busy), .gnt_id_o(gnt_id)
    );

    task automatic clear_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // T2: port 0 write then read-back, two cycles per access.
    task automatic test_write_read();
        apply_reset();
        m0_we = 1'b1; m0_addr = 10'h010; m0_wdata = 32'hDEADBEEF; m0_req = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t2_wr_busy: got %0h want 1", busy); end
        n_checks++; if (dm_dmwr !== 1'b1) begin n_fail++; $display("FAIL t2_wr_dmwr: got %0h want 1", dm_dmwr); end
        n_checks++; if (dm_addr !== 10'h010) begin n_fail++; $display("FAIL t2_wr_addr: got %h want 010", dm_addr); end
        n_checks++; if (dm_din !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t2_wr_din: got %h want deadbeef", dm_din); end
        n_checks++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL t2_wr_early_ack: got %0h want 0", m0_ack); end
        tick();
        n_checks++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL t2_wr_ack: got %0h want 1", m0_ack); end
        n_checks++; if ({busy, dm_dmwr} !== 2'b00) begin n_fail++; $display("FAIL t2_wr_idle: got %b want 00", {busy, dm_dmwr}); end
        n_checks++; if (mem[16] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t2_mem: got %h want deadbeef", mem[16]); end
        n_checks++; if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL t2_wr_rdata: got %h want 0", m0_rdata); end
        m0_req = 1'b0;
        tick();
        n_checks++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL t2_ack_pulse: got %0h want 0", m0_ack); end
        m0_we = 1'b0; m0_req = 1'b1;
        tick();
        n_checks++; if ({busy, dm_dmwr} !== 2'b10) begin n_fail++; $display("FAIL t2_rd_access: got %b want 10", {busy, dm_dmwr}); end
        tick();
        n_checks++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL t2_rd_ack: got %0h want 1", m0_ack); end
        n_checks++; if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t2_rd_data: got %h want deadbeef", m0_rdata); end
        m0_req = 1'b0;
        tick();
    endtask

    // T1: asynchronous reset mid-cycle clears every output at once.
    task automatic test_reset();
        m1_we = 1'b0; m1_addr = 10'h3FF; m1_wdata = 32'h12345678; m1_req = 1'b1;
        tick();
        n_checks++; if ({busy, gnt_id} !== 2'b11) begin n_fail++; $display("FAIL t1_pre: got %b want 11", {busy, gnt_id}); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({busy, gnt_id, dm_dmwr, m0_ack, m1_ack} !== 5'b0) begin n_fail++; $display("FAIL t1_ctrl: got %b want 00000", {busy, gnt_id, dm_dmwr, m0_ack, m1_ack}); end
        n_checks++; if (dm_addr !== 10'h0) begin n_fail++; $display("FAIL t1_addr: got %h want 0", dm_addr); end
        n_checks++; if (dm_din !== 32'h0) begin n_fail++; $display("FAIL t1_din: got %h want 0", dm_din); end
        n_checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_fail++; $display("FAIL t1_rdata: got %h %h want 0 0", m0_rdata, m1_rdata); end
        m1_req = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        n_checks++; if ({busy, m1_ack} !== 2'b00) begin n_fail++; $display("FAIL t1_after: got %b want 00", {busy, m1_ack}); end
    endtask

    // T3: simultaneous requests after reset; port 0 first, port 1 two cycles later.
    task automatic test_tie();
        mem[4] = 32'h11; mem[8] = 32'h22;
        apply_reset();
        m0_addr = 10'h004; m1_addr = 10'h008; m0_req = 1'b1; m1_req = 1'b1;
        tick();
        n_checks++; if ({busy, gnt_id} !== 2'b10) begin n_fail++; $display("FAIL t3_gnt0: got %b want 10", {busy, gnt_id}); end
        tick();
        n_checks++; if ({m0_ack, m1_ack} !== 2'b10) begin n_fail++; $display("FAIL t3_ack0: got %b want 10", {m0_ack, m1_ack}); end
        n_checks++; if (m0_rdata !== 32'h11) begin n_fail++; $display("FAIL t3_rdata0: got %h want 11", m0_rdata); end
        m0_req = 1'b0;
        tick();
        n_checks++; if ({busy, gnt_id, m0_ack} !== 3'b110) begin n_fail++; $display("FAIL t3_gnt1: got %b want 110", {busy, gnt_id, m0_ack}); end
        tick();
        n_checks++; if ({m0_ack, m1_ack} !== 2'b01) begin n_fail++; $display("FAIL t3_ack1: got %b want 01", {m0_ack, m1_ack}); end
        n_checks++; if (m1_rdata !== 32'h22) begin n_fail++; $display("FAIL t3_rdata1: got %h want 22", m1_rdata); end
        m1_req = 1'b0;
        tick();
    endtask

    // T4: both requests held; grants alternate, four acks each.
    task automatic test_back_to_back();
        int acks0 = 0;
        int acks1 = 0;
        logic exp_g;
        apply_reset();
        m0_addr = 10'h004; m1_addr = 10'h008; m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_g = ((k % 2) == 1) ? 1'b1 : 1'b0;
            tick();
            n_checks++; if ({busy, gnt_id} !== {1'b1, exp_g}) begin n_fail++; $display("FAIL t4_gnt[%0d]: got %b want %b", k, {busy, gnt_id}, {1'b1, exp_g}); end
            tick();
            if (m0_ack) acks0++;
            if (m1_ack) acks1++;
            n_checks++; if ({m0_ack, m1_ack} !== {~exp_g, exp_g}) begin n_fail++; $display("FAIL t4_ack[%0d]: got %b want %b", k, {m0_ack, m1_ack}, {~exp_g, exp_g}); end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        n_checks++; if (acks0 !== 4 || acks1 !== 4) begin n_fail++; $display("FAIL t4_count: got %0d/%0d want 4/4", acks0, acks1); end
        tick(); tick();
    endtask

    // T5: port 1 locked for three writes while port 0 waits.
    task automatic test_lock();
        int order [0:3];
        int n_gnt = 0;
        int m1_done = 0;
        logic m0_done = 1'b0;
        mem[10'h040] = 32'h55;
        mem[10'h030] = 32'h0; mem[10'h031] = 32'h0; mem[10'h032] = 32'h0;
        for (int i = 0; i < 4; i++) order[i] = 9;
        apply_reset();
        m1_we = 1'b1; m1_lock = 1'b1; m1_addr = 10'h030; m1_wdata = 32'hA0; m1_req = 1'b1;
        tick();
        if (busy) begin order[n_gnt] = int'(gnt_id); n_gnt++; end
        m0_we = 1'b0; m0_addr = 10'h040; m0_req = 1'b1;
        for (int cyc = 0; cyc < 40 && !m0_done; cyc++) begin
            tick();
            if (busy && n_gnt < 4) begin order[n_gnt] = int'(gnt_id); n_gnt++; end
            if (m1_ack) begin
                m1_done++;
                if (m1_done < 3) begin
                    m1_addr = 10'h030 + AW'(m1_done);
                    m1_wdata = 32'hA0 + 32'(m1_done);
                end else begin
                    m1_req = 1'b0; m1_lock = 1'b0;
                end
            end
            if (m0_ack) begin
                m0_done = 1'b1;
                m0_req = 1'b0;
            end
        end
        n_checks++; if (m0_done !== 1'b1) begin n_fail++; $display("FAIL t5_timeout: got m0 done %0b want 1", m0_done); end
        n_checks++; if (order[0] != 1 || order[1] != 1 || order[2] != 1 || order[3] != 0) begin n_fail++; $display("FAIL t5_order: got %0d%0d%0d%0d want 1110", order[0], order[1], order[2], order[3]); end
        n_checks++; if (m0_rdata !== 32'h55) begin n_fail++; $display("FAIL t5_rdata: got %h want 55", m0_rdata); end
        n_checks++; if (mem[10'h030] !== 32'hA0 || mem[10'h031] !== 32'hA1 || mem[10'h032] !== 32'hA2) begin n_fail++; $display("FAIL t5_mem: got %h %h %h want a0 a1 a2", mem[10'h030], mem[10'h031], mem[10'h032]); end
        tick();
    endtask

    // T6: reset during a write access suppresses the write and the ack.
    task automatic test_reset_mid_access();
        mem[10'h020] = 32'h0;
        apply_reset();
        m0_we = 1'b1; m0_addr = 10'h020; m0_wdata = 32'hCAFE0000; m0_req = 1'b1;
        tick();
        n_checks++; if ({busy, dm_dmwr} !== 2'b11) begin n_fail++; $display("FAIL t6_access: got %b want 11", {busy, dm_dmwr}); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({busy, dm_dmwr, gnt_id} !== 3'b000) begin n_fail++; $display("FAIL t6_async: got %b want 000", {busy, dm_dmwr, gnt_id}); end
        m0_req = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL t6_no_ack: got %0h want 0", m0_ack); end
        tick(); tick();
        n_checks++; if ({m0_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL t6_idle: got %b want 00", {m0_ack, busy}); end
        n_checks++; if (mem[10'h020] !== 32'h0) begin n_fail++; $display("FAIL t6_mem: got %h want 0", mem[10'h020]); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        clear_inputs();
        rst = 1'b1;
        #2;
        n_checks++; if ({busy, gnt_id, dm_dmwr, m0_ack, m1_ack} !== 5'b0) begin n_fail++; $display("FAIL por_ctrl: got %b want 00000", {busy, gnt_id, dm_dmwr, m0_ack, m1_ack}); end
        test_write_read();
        test_reset();
        test_tie();
        test_back_to_back();
        test_lock();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
